// File: rtl/decimal_key_pkg.sv
// Shared types and helpers for the debounced key encoder: FSM state,
// lowest-set-bit encode, multi-key detect and FIFO width helpers.
package decimal_key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB,
        PRESSED,
        REL
    } key_state_e;

    localparam int MAX_KEYS = 64;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a completely full FIFO is representable.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int lowest_index(input logic [MAX_KEYS-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic is_multi(input logic [MAX_KEYS-1:0] vec);
        return (vec & (vec - 64'd1)) != '0;
    endfunction

endpackage

// File: rtl/decimal_key_encoder_if.sv
// Key-input / code-output bundle; the encoder sits on the slave side.
interface decimal_key_encoder_if #(
    parameter int N_KEYS = 10,
    parameter int CODE_W = 4,
    parameter int CNT_W  = 3
);
    logic [N_KEYS-1:0] keys;
    logic              out_ready;
    logic              out_valid;
    logic [CODE_W-1:0] out_code;
    logic              out_multi;
    logic              any_key;
    logic              overflow;
    logic [CNT_W-1:0]  count;

    modport master (
        output keys, out_ready,
        input  out_valid, out_code, out_multi, any_key, overflow, count
    );

    modport slave (
        input  keys, out_ready,
        output out_valid, out_code, out_multi, any_key, overflow, count
    );
endinterface

// File: rtl/decimal_key_encoder_fifo.sv
// First-word fall-through code queue with a sticky overflow flag; a push
// into a full queue is accepted only when a pop frees a slot that cycle.
module key_code_fifo
    import decimal_key_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 5,
    localparam int PTR_W = fifo_ptr_w(DEPTH),
    localparam int CNT_W = fifo_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (push && !push_ok) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Stale storage is masked so the head reads zero while empty.
    assign rdata    = empty ? '0 : mem[rd_ptr];
    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/decimal_key_encoder.sv
// Debounces raw key lines, encodes each new press to the lowest active
// index plus a multi-key flag, and queues the result for a valid/ready sink.
module decimal_key_encoder
    import decimal_key_pkg::*;
#(
    parameter int N_KEYS  = 10,
    parameter int CODE_W  = 4,
    parameter int DEB_CYC = 4,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    decimal_key_encoder_if.slave bus
);

    localparam int DC_W  = $clog2(DEB_CYC + 1);
    localparam int CNT_W = fifo_cnt_w(DEPTH);

    key_state_e        state;
    logic [N_KEYS-1:0] key_q;
    logic [N_KEYS-1:0] snap;
    logic [DC_W-1:0]   cnt;
    logic              any_key_q;
    logic              cnt_done;
    logic              push;
    logic [CODE_W:0]   entry;
    logic [CODE_W:0]   head;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_ovf;

    assign cnt_done = (cnt == DC_W'(DEB_CYC - 1));
    // The push fires on the same edge the FSM moves DEB -> PRESSED.
    assign push     = (state == DEB) && (key_q != '0) && (key_q == snap) && cnt_done;
    assign entry    = {is_multi(MAX_KEYS'(snap)), CODE_W'(lowest_index(MAX_KEYS'(snap)))};

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q     <= '0;
            snap      <= '0;
            cnt       <= '0;
            state     <= IDLE;
            any_key_q <= 1'b0;
        end else begin
            key_q <= bus.keys;
            case (state)
                IDLE: begin
                    if (key_q != '0) begin
                        state <= DEB;
                        snap  <= key_q;
                        cnt   <= '0;
                    end
                end
                DEB: begin
                    if (key_q == '0) begin
                        state <= IDLE;
                    end else if (key_q != snap) begin
                        snap <= key_q;
                        cnt  <= '0;
                    end else if (cnt_done) begin
                        state     <= PRESSED;
                        any_key_q <= 1'b1;
                    end else begin
                        cnt <= cnt + DC_W'(1);
                    end
                end
                PRESSED: begin
                    // A changed chord while held is ignored until full release.
                    if (key_q == '0) begin
                        state <= REL;
                        cnt   <= '0;
                    end
                end
                REL: begin
                    if (key_q != '0) begin
                        state <= PRESSED;
                    end else if (cnt_done) begin
                        state     <= IDLE;
                        any_key_q <= 1'b0;
                    end else begin
                        cnt <= cnt + DC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    key_code_fifo #(
        .DEPTH (DEPTH),
        .W     (CODE_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wdata    (entry),
        .pop      (bus.out_ready),
        .rdata    (head),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_ovf)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_code  = head[CODE_W-1:0];
    assign bus.out_multi = head[CODE_W];
    assign bus.any_key   = any_key_q;
    assign bus.overflow  = fifo_ovf;
    assign bus.count     = fifo_count;

endmodule

// File: doc/decimal_key_encoder.md
Name: decimal_key_encoder

Overview:
- Parametrised, clocked successor to the combinational one-hot-to-binary encoder.
- Takes N_KEYS raw key/switch lines and debounces them.
- Each new debounced press is priority-encoded to a binary code, with a flag when more than one key is active.
- Codes are queued in a small FIFO and drained through a valid/ready handshake. Sits between board switches/keypad and the downstream display/controller logic.

Parameters:
- N_KEYS, 10, number of key input lines (2..64).
- CODE_W, 4, output code width; must satisfy 2**CODE_W >= N_KEYS.
- DEB_CYC, 4, number of consecutive stable cycles required to accept a press or a release (>=1).
- DEPTH, 4, FIFO entries; power of 2, >=2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- keys  in  N_KEYS  raw key lines, active-high, assumed synchronous to clk.
- out_ready  in  1  consumer accepts head entry.
- out_valid  out  1  FIFO non-empty.
- out_code  out  CODE_W  head entry code (lowest active key index).
- out_multi  out  1  head entry was captured with more than one key active.
- any_key  out  1  debounced key-held indicator (registered CHK).
- overflow  out  1  sticky; a press was dropped because the FIFO was full.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, debounce counter=0, snapshot=0, input register=0, FIFO emptied.
  - All outputs 0 on the following cycle.
  - Reset mid-press discards everything. A key still held after reset is treated as a new press.
- Input stage: key_q <= keys every cycle; the FSM uses key_q only.
- FSM states and transitions:
  - IDLE: key_q!=0 -> DEB, snap<=key_q, cnt<=0.
  - DEB:
    - key_q==0 -> IDLE.
    - key_q!=snap (nonzero) -> snap<=key_q, cnt<=0, stay in DEB.
    - key_q==snap and cnt==DEB_CYC-1 -> PRESSED and push one entry.
    - Otherwise cnt++.
  - PRESSED:
    - key_q==0 -> REL, cnt<=0.
    - A different nonzero pattern causes no event; keys must be released first.
  - REL:
    - key_q!=0 -> PRESSED (bounce, no push).
    - cnt==DEB_CYC-1 -> IDLE.
    - Otherwise cnt++.
- Entry contents: code = index of the lowest set bit of snap; multi = (popcount(snap)>1).
- Latency: keys stable from edge k gives out_valid=1 after edge k+DEB_CYC+2. With DEB_CYC=4 that is 6 edges.
- any_key=1 while state is PRESSED or REL.
- FIFO behaviour:
  - First-word fall-through. out_code/out_multi are valid whenever out_valid=1 and are held stable until popped.
  - Pop when out_valid && out_ready.
  - Push when full with a simultaneous pop: accepted, count unchanged, no overflow.
  - Push when full without a pop: entry dropped, overflow<=1.
  - overflow is sticky until rst.
  - Pop when empty: ignored.
  - Read/write pointers wrap modulo DEPTH.
- Only one push can occur per press, so there is at most one push per cycle.

Decomposition:
- Package decimal_key_pkg holds:
  - FSM state enum {IDLE, DEB, PRESSED, REL}.
  - Functions lowest_index(vec) and is_multi(vec).
  - Width helper constants derived from DEPTH.
- One sub-module, key_code_fifo: parametrised by DEPTH and entry width CODE_W+1, with push/pop/full/empty/count/overflow.
- The top level contains the input register, the FSM, the encode logic and the key_code_fifo instance.

Test Plan:
- Reset, then keys=1<<7 held 12 cycles with out_ready=0 -> out_valid rises after edge k+6, out_code=7, out_multi=0, count=1, any_key=1. Release keys -> any_key drops DEB_CYC+2 cycles later; count stays 1.
- Key 3 toggling on/off every 2 cycles for 8 cycles, then held 10 cycles -> exactly one entry (code=3). A bounce during REL produces no second entry.
- keys=10'b10_0000_0100 (keys 2 and 9) held -> code=2, out_multi=1.
- Five separate presses 1,4,6,8,9 with out_ready=0, DEPTH=4 -> count=4, overflow=1. Then out_ready=1 -> pops 1,4,6,8 in order, then out_valid=0. overflow stays 1 until rst.
- FIFO full, fifth press completing on the same cycle out_ready=1 -> push accepted, overflow=0, count=4, new tail code correct.
- rst pulsed while PRESSED on key 5 (still held) -> next cycle all outputs 0 and count=0. A fresh code 5 appears DEB_CYC+2 cycles after rst deasserts.
